jk_ff_seq_driver: RTL and testbench

- Drives J/K of an external posedge JK flip-flop so its Q output follows a loaded bit pattern.
- Reads Q back after each step and checks it against the target bit.
- Acts as the initiator/checker end of the J/K/Q interface. Used for on-board self-test of JK flip-flop cells and as a reusable stimulus block in simulation.

---
 rtl/jk_ff_seq_driver.sv | 165 ++++++++++++++++
 tb/tb_jk_ff_seq_driver.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/jk_ff_seq_driver.sv
// jk_ff_seq_driver: drives J/K of an external posedge JK flip-flop so that its
// Q follows a latched bit pattern (bit 0 first), then checks Q after each step.
// Each bit takes three cycles: DRIVE (compute excitation), APPLY (hold J/K while
// the flip-flop samples them), CHECK (compare Q with the target bit).
// Optional build macro: JK_TOGGLE_EN -- when defined, a required change of state
// on bits 1..LEN-1 is driven as a toggle (J=K=1) instead of a set/reset.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for START; J=K=0; READY high
// S_DRIVE | load J/K with the excitation for pat[IDX] and current Q
// S_APPLY | J/K held stable; flip-flop samples at the closing edge
// S_CHECK | compare Q with pat[IDX]; advance IDX or finish
// S_FIN   | one-cycle DONE pulse, then back to idle
module jk_ff_seq_driver #(
    parameter int LEN   = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             START,
    input  logic [LEN-1:0]   PATTERN,
    output logic             READY,
    output logic             J,
    output logic             K,
    input  logic             Q,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [CNT_W-1:0] IDX
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRIVE = 3'd1,
        S_APPLY = 3'd2,
        S_CHECK = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(LEN - 1);

    state_t             state_q, state_d;
    logic [LEN-1:0]     pat_q, pat_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               err_q, err_d;
    logic               j_q, j_d;
    logic               k_q, k_d;
    logic               done_q, done_d;
    logic               tgt;

    // Select the target bit pat[IDX] without a variable-width bit select.
    always_comb begin
        tgt = 1'b0;
        for (int i = 0; i < LEN; i++) begin
            if (idx_q == CNT_W'(i)) tgt = pat_q[i];
        end
    end

    // Next-state, J/K excitation and error bookkeeping.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        idx_d     = idx_q;
        err_cnt_d = err_cnt_q;
        err_d     = err_q;
        j_d       = j_q;
        k_d       = k_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                j_d = 1'b0;
                k_d = 1'b0;
                if (START) begin
                    pat_d     = PATTERN;
                    idx_d     = '0;
                    err_d     = 1'b0;
                    err_cnt_d = '0;
                    state_d   = S_DRIVE;
                end
            end
            S_DRIVE: begin
                // Bit 0 is always forced: the flip-flop has no reset, so Q may be unknown.
                if (idx_q == '0) begin
                    j_d = tgt;
                    k_d = ~tgt;
                end else if (Q != tgt) begin
`ifdef JK_TOGGLE_EN
                    j_d = 1'b1;
                    k_d = 1'b1;
`else
                    j_d = tgt;
                    k_d = ~tgt;
`endif
                end else begin
                    j_d = 1'b0;
                    k_d = 1'b0;
                end
                state_d = S_APPLY;
            end
            S_APPLY: begin
                j_d     = 1'b0;
                k_d     = 1'b0;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (Q != tgt) begin
                    err_d = 1'b1;
                    if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
                end
                if (idx_q == IDX_LAST) begin
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    idx_d   = idx_q + CNT_W'(1);
                    state_d = S_DRIVE;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                j_d     = 1'b0;
                k_d     = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= S_IDLE;
            pat_q     <= '0;
            idx_q     <= '0;
            err_cnt_q <= '0;
            err_q     <= 1'b0;
            j_q       <= 1'b0;
            k_q       <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            idx_q     <= idx_d;
            err_cnt_q <= err_cnt_d;
            err_q     <= err_d;
            j_q       <= j_d;
            k_q       <= k_d;
            done_q    <= done_d;
        end
    end

    assign READY   = (state_q == S_IDLE);
    assign BUSY    = (state_q == S_DRIVE) || (state_q == S_APPLY) || (state_q == S_CHECK);
    assign DONE    = done_q;
    assign ERR     = err_q;
    assign ERR_CNT = err_cnt_q;
    assign IDX     = idx_q;
    assign J       = j_q;
    assign K       = k_q;

endmodule

// File: tb/tb_jk_ff_seq_driver.sv
// Directed bench for jk_ff_seq_driver with a behavioural JK flip-flop model
// (optionally stuck at 0) on the J/K/Q interface.
module tb_jk_ff_seq_driver;

    logic       CLK = 1'b0;
    logic       RST_n = 1'b0;
    logic       START = 1'b0;
    logic [7:0] PATTERN = 8'h00;
    logic       Q;
    logic       READY, J, K, BUSY, DONE, ERR;
    logic [3:0] ERR_CNT, IDX;

    logic q_ff  = 1'b0;
    logic stuck = 1'b0;

    int checks = 0;
    int errors = 0;

    jk_ff_seq_driver #(.LEN(8), .CNT_W(4)) dut (
        .CLK     (CLK),
        .RST_n   (RST_n),
        .START   (START),
        .PATTERN (PATTERN),
        .READY   (READY),
        .J       (J),
        .K       (K),
        .Q       (Q),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .ERR     (ERR),
        .ERR_CNT (ERR_CNT),
        .IDX     (IDX)
    );

    always #5 CLK = ~CLK;

    // JK flip-flop model
    always @(posedge CLK) begin
        case ({J, K})
            2'b10:   q_ff <= 1'b1;
            2'b01:   q_ff <= 1'b0;
            2'b11:   q_ff <= ~q_ff;
            default: q_ff <= q_ff;
        endcase
    end

    assign Q = stuck ? 1'b0 : q_ff;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One run started at a negedge; ends at the negedge after DONE (IDLE),
    // so a following call starts back-to-back. Optional START injection and
    // reset-abort at given cycle numbers (cycle 1 = DRIVE of bit 0).
    task automatic run(input logic [7:0] p, input int inj_cyc, input logic [7:0] inj_pat,
                       input int rst_cyc, input int exp_err, input int exp_cnt);
        logic [7:0] qseq;
        logic [7:0] exp_q;
        int  done_cyc;
        int  busy_bad;
        int  jk_idle_bad;
        int  done_bad;
        int  bi, ph;
        logic t, qp, ej, ek;
        qseq = 8'h00;
        done_cyc = 0;
        busy_bad = 0;
        jk_idle_bad = 0;
        exp_q = stuck ? 8'h00 : p;
        START = 1'b1;
        PATTERN = p;
        @(posedge CLK);
        #1;
        START = 1'b0;
        for (int cyc = 1; cyc <= 40 && done_cyc == 0; cyc++) begin
            @(negedge CLK);
            START = 1'b0;
            if (cyc == inj_cyc) begin
                START = 1'b1;
                PATTERN = inj_pat;
            end
            if (cyc == rst_cyc) begin
                chk("pre_rst_errcnt", ERR_CNT, exp_cnt);
                chk("pre_rst_jk", {J, K}, 2'b10);
                RST_n = 1'b0;
                #1;
                chk("rst_j", J, 0);
                chk("rst_k", K, 0);
                chk("rst_ready", READY, 1);
                chk("rst_busy", BUSY, 0);
                chk("rst_errcnt", ERR_CNT, 0);
                chk("rst_err", ERR, 0);
                chk("rst_idx", IDX, 0);
                done_bad = 0;
                repeat (3) begin
                    @(negedge CLK);
                    if (DONE) done_bad++;
                end
                chk("rst_no_done", done_bad, 0);
                RST_n = 1'b1;
                return;
            end
            if (DONE) begin
                done_cyc = cyc;
            end else if (cyc <= 24) begin
                bi = (cyc - 1) / 3;
                ph = (cyc - 1) % 3;
                if (READY || !BUSY) busy_bad++;
                if (ph == 1) begin
                    t  = p[bi];
                    qp = stuck ? 1'b0 : ((bi == 0) ? 1'b0 : p[bi-1]);
                    if (bi == 0) begin
                        ej = t; ek = ~t;
                    end else if (qp == t) begin
                        ej = 1'b0; ek = 1'b0;
                    end else begin
`ifdef JK_TOGGLE_EN
                        ej = 1'b1; ek = 1'b1;
`else
                        ej = t; ek = ~t;
`endif
                    end
                    chk($sformatf("jk_p%02h_b%0d", p, bi), {J, K}, {ej, ek});
                end else if (J || K) begin
                    jk_idle_bad++;
                end
                if (ph == 2) qseq[bi] = Q;
            end
        end
        if (done_cyc == 0) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk($sformatf("done_lat_p%02h", p), done_cyc, 25);
            chk($sformatf("qseq_p%02h", p), qseq, exp_q);
            chk($sformatf("err_p%02h", p), ERR, exp_err);
            chk($sformatf("errcnt_p%02h", p), ERR_CNT, exp_cnt);
            chk($sformatf("idx_p%02h", p), IDX, 7);
            chk($sformatf("fin_ready_p%02h", p), {READY, BUSY}, 2'b00);
            chk($sformatf("busy_p%02h", p), busy_bad, 0);
            chk($sformatf("jk_quiet_p%02h", p), jk_idle_bad, 0);
            @(negedge CLK);
            chk($sformatf("idle_p%02h", p), {READY, BUSY, DONE}, 3'b100);
            chk($sformatf("hold_err_p%02h", p), ERR_CNT, exp_cnt);
        end
    endtask

    initial begin
        RST_n = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_ready", READY, 1);
        chk("reset_busy", BUSY, 0);
        chk("reset_jk", {J, K}, 0);
        chk("reset_done", DONE, 0);
        chk("reset_err", ERR, 0);
        chk("reset_errcnt", ERR_CNT, 0);
        chk("reset_idx", IDX, 0);
        RST_n = 1'b1;
        @(negedge CLK);

        stuck = 1'b0;
        run(8'hA5, 0, 8'h00, 0, 0, 0);
        run(8'hFF, 0, 8'h00, 0, 0, 0);
        stuck = 1'b1;
        run(8'h0F, 0, 8'h00, 0, 1, 4);
        run(8'h00, 0, 8'h00, 0, 0, 0);
        stuck = 1'b0;
        run(8'hA5, 12, 8'h3C, 0, 0, 0);
        run(8'h55, 0, 8'h00, 0, 0, 0);
        stuck = 1'b1;
        run(8'h1F, 0, 8'h00, 14, 1, 4);
        stuck = 1'b0;
        run(8'h3C, 0, 8'h00, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
